store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
// - FIFO of committed word stores between the MEM stage and the d-cache. It frees the pipeline from waiting on cache write latency.
// - Drains entries in program order to the d-cache write port.
// - Serves the load_forward_ifc "in" side: a load whose word address matches a buffered store gets that store's data in the same cycle.
// PARAMETERS
// - DEPTH       4   number of entries, power of two, >= 2
// - ADDR_WIDTH  32  byte address width
// - DATA_WIDTH  32  store data width (one word)
// PORTS
// - clk             in   1           core clock
// - rst_n           in   1           synchronous active-low reset
// - st_valid        in   1           MEM stage presents a committed store
// - st_addr         in   ADDR_WIDTH  store byte address (word aligned)
// - st_data         in   DATA_WIDTH  store data
// - st_ready        out  1           buffer accepts the store this cycle
// - fwd_addr_valid  in   1           load lookup request (load_forward_ifc.addr_valid)
// - fwd_addr        in   ADDR_WIDTH  load byte address
// - fwd_data_valid  out  1           lookup hit
// - fwd_data        out  DATA_WIDTH  forwarded word, valid when fwd_data_valid
// - drain_valid     out  1           head entry presented to d-cache
// - drain_addr      out  ADDR_WIDTH  head address
// - drain_data      out  DATA_WIDTH  head data
// - drain_ready     in   1           d-cache accepts the head this cycle
// - count           out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
// - empty           out  1           count == 0; hazard unit gates fence/uncached ops on it
// BEHAVIOUR
// - Storage: circular array indexed by head/tail pointers of $clog2(DEPTH) bits.
//   - Pointers wrap DEPTH-1 -> 0.
//   - count tracks occupancy separately, so full and empty are unambiguous.
// - Reset (rst_n low at a clk edge): head=tail=count=0; all entry valid bits cleared.
//   - Outputs after reset: st_ready=1, drain_valid=0, fwd_data_valid=0, empty=1, count=0.
//   - drain_addr, drain_data and fwd_data are don't-care.
//   - Reset mid-operation discards every buffered store; no drain handshake completes in that cycle.
// - Enqueue: on st_valid && st_ready, write {st_addr,st_data} at tail, then tail++.
// - st_ready = (count != DEPTH). It is combinational, not registered.
// - Full buffer: st_ready=0 even if drain_ready=1 in the same cycle (no bypass). The MEM stage stalls one cycle.
// - Drain: drain_valid = !empty. drain_* show the head entry combinationally.
//   - On drain_valid && drain_ready: head++ at the clk edge.
// - Enqueue and dequeue in the same cycle: count is unchanged, and both pointers advance.
// - Empty buffer: drain_valid=0. drain_ready is ignored.
// - Forwarding: combinational, zero latency. Compare fwd_addr[ADDR_WIDTH-1:2] against every valid entry.
//   - Hit: fwd_data_valid = fwd_addr_valid && any match. fwd_data comes from the YOUNGEST match, i.e. the one nearest tail in program order.
//   - The head entry being drained this cycle is still searchable. The store being enqueued this cycle is not; it becomes visible the next cycle.
//   - fwd_addr_valid=0 forces fwd_data_valid=0.
// - Address bits [1:0] are not compared. Only word stores enter the buffer; sub-word stores are handled by the MEM stage before st_valid.
// - count arithmetic: count_next = count + enq - deq. It never exceeds DEPTH or goes below 0. The bench asserts both bounds.
// CONFIGURATION
// - Macro STORE_BUFFER_COALESCE_EN.
// - Defined: a store merges in place when all of these hold:
//   - count > 0;
//   - st_addr[ADDR_WIDTH-1:2] equals the youngest entry (tail-1) word address;
//   - that entry is not the head being drained this cycle.
// - Effect of a merge:
//   - st_data overwrites the entry's data; tail and count are unchanged.
//   - st_ready=1 even when full, because a merge needs no free slot.
// - Not defined: every accepted store allocates a new entry. There is no merge logic or comparator on the enqueue path.
// TESTING
// - Reset, then 4 stores 0x100..0x10C with data 0xA0..0xA3, drain_ready=0 -> count=4, st_ready=0, drain_addr=0x100, drain_data=0xA0.
// - Full with st_valid=1 and drain_ready=1 for one cycle -> store not accepted; head->0x104; next cycle st_ready=1; count=4 after the accept.
// - Stores 0x200=0x11 then 0x200=0x22 (not coalescing); load 0x202 -> fwd_data_valid=1, fwd_data=0x22. Load 0x300 -> fwd_data_valid=0.
// - Wrap: 10 alternating enq/deq with continuous drain_ready=1 -> drained data exactly in program order across pointer wrap; empty=1 at end.
// - Reset asserted with count=3 -> next cycle count=0, drain_valid=0, empty=1; a load at a previously buffered address misses.
// - With STORE_BUFFER_COALESCE_EN: store 0x400=0x5 then 0x400=0x6 on consecutive cycles -> count=1, drain_data=0x6.
//   - Without the macro: count=2; 0x5 is drained before 0x6.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: in-order FIFO of committed word stores feeding the d-cache write port,
// with same-cycle load forwarding. Optional in-place merging under STORE_BUFFER_COALESCE_EN.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    st_valid,
    input  logic [ADDR_WIDTH-1:0]   st_addr,
    input  logic [DATA_WIDTH-1:0]   st_data,
    output logic                    st_ready,
    input  logic                    fwd_addr_valid,
    input  logic [ADDR_WIDTH-1:0]   fwd_addr,
    output logic                    fwd_data_valid,
    output logic [DATA_WIDTH-1:0]   fwd_data,
    output logic                    drain_valid,
    output logic [ADDR_WIDTH-1:0]   drain_addr,
    output logic [DATA_WIDTH-1:0]   drain_data,
    input  logic                    drain_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic                  w_full;
    logic                  w_deq;
    logic                  w_alloc;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hitData;
    logic [PW-1:0]         w_scanIdx;
    logic [1:0]            w_unused_fwd_lsbs;

    assign w_unused_fwd_lsbs = fwd_addr[1:0];

    assign w_full      = (r_count == FULL_COUNT);
    assign empty       = (r_count == '0);
    assign count       = r_count;
    assign drain_valid = !empty;
    assign drain_addr  = r_addr[r_head];
    assign drain_data  = r_data[r_head];
    assign w_deq       = drain_valid && drain_ready;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] w_youngest;
    logic          w_mergeOk;
    logic          w_merge;

    // A merge reuses the youngest slot, so it is allowed even when the buffer is full.
    assign w_youngest = r_tail - PW'(1);
    assign w_mergeOk  = (r_count != '0)
                     && (st_addr[ADDR_WIDTH-1:2] == r_addr[w_youngest][ADDR_WIDTH-1:2])
                     && !(w_deq && (w_youngest == r_head));
    assign st_ready   = !w_full || w_mergeOk;
    assign w_merge    = st_valid && w_mergeOk;
    assign w_alloc    = st_valid && !w_mergeOk && !w_full;
`else
    assign st_ready   = !w_full;
    assign w_alloc    = st_valid && !w_full;
`endif

    // Scan oldest to youngest so the last match, the youngest store, wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hitData = '0;
        w_scanIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_scanIdx = r_head + PW'(i);
            if (r_valid[w_scanIdx] &&
                (r_addr[w_scanIdx][ADDR_WIDTH-1:2] == fwd_addr[ADDR_WIDTH-1:2])) begin
                w_hit     = 1'b1;
                w_hitData = r_data[w_scanIdx];
            end
        end
        fwd_data_valid = fwd_addr_valid && w_hit;
        fwd_data       = w_hitData;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_alloc) - CW'(w_deq);
        end
    end

    // Payload storage needs no reset; the valid bits and count gate every use of it.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= st_addr;
            r_data[r_tail] <= st_data;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        if (w_merge) begin
            r_data[w_youngest] <= st_data;
        end
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: fill/full, drain order, forwarding,
// pointer wrap, mid-operation reset and (optionally) store coalescing.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        fwd_addr_valid;
    logic [31:0] fwd_addr;
    logic        fwd_data_valid;
    logic [31:0] fwd_data;
    logic        drain_valid;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic        drain_ready;
    logic [2:0]  count;
    logic        empty;

    int nCompared   = 0;
    int nMismatched = 0;
    bit boundArmed  = 1'b0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .fwd_addr_valid (fwd_addr_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data_valid (fwd_data_valid),
        .fwd_data       (fwd_data),
        .drain_valid    (drain_valid),
        .drain_addr     (drain_addr),
        .drain_data     (drain_data),
        .drain_ready    (drain_ready),
        .count          (count),
        .empty          (empty)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic stValid, input logic [31:0] addr,
                                 input logic [31:0] data, input logic drainRdy,
                                 input logic fwdValid, input logic [31:0] fAddr);
        st_valid       = stValid;
        st_addr        = addr;
        st_data        = data;
        drain_ready    = drainRdy;
        fwd_addr_valid = fwdValid;
        fwd_addr       = fAddr;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Occupancy must stay within 0..DEPTH; an underflow wraps the unsigned count above 4.
    always @(negedge clk) begin
        if (boundArmed) checkOutput("countBound", 32'(count <= 3'd4), 32'd1);
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        boundArmed = 1'b1;

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100);
        checkOutput("rstCount",      32'(count),          32'd0);
        checkOutput("rstStReady",    32'(st_ready),       32'd1);
        checkOutput("rstDrainValid", 32'(drain_valid),    32'd0);
        checkOutput("rstFwdValid",   32'(fwd_data_valid), 32'd0);
        checkOutput("rstEmpty",      32'(empty),          32'd1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, 32'h0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10A);
        checkOutput("fillCount",     32'(count),          32'd4);
        checkOutput("fillStReady",   32'(st_ready),       32'd0);
        checkOutput("fillDrainVal",  32'(drain_valid),    32'd1);
        checkOutput("fillDrainAddr", drain_addr,          32'h100);
        checkOutput("fillDrainData", drain_data,          32'hA0);
        checkOutput("fillFwdValid",  32'(fwd_data_valid), 32'd1);
        checkOutput("fillFwdData",   fwd_data,            32'hA2);

        // Full with a drain in the same cycle: no bypass, the store must retry.
        applyStimulus(1'b1, 32'h110, 32'hA4, 1'b1, 1'b0, 32'h0);
        checkOutput("fullNoBypass", 32'(st_ready), 32'd0);
        tick();
        applyStimulus(1'b1, 32'h110, 32'hA4, 1'b0, 1'b0, 32'h0);
        checkOutput("afterDrainCount", 32'(count),    32'd3);
        checkOutput("afterDrainHead",  drain_addr,    32'h104);
        checkOutput("afterDrainReady", 32'(st_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("retryCount", 32'(count),  32'd4);
        checkOutput("retryHead",  drain_data,  32'hA1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            checkOutput("drainOrder", drain_data, 32'hA1 + 32'(i));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("drainedEmpty",     32'(empty),       32'd1);
        checkOutput("drainedDrainVal",  32'(drain_valid), 32'd0);
        tick();
        checkOutput("emptyIgnoresReady", 32'(count), 32'd0);

        applyStimulus(1'b1, 32'h200, 32'h11, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h200, 32'h22, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h202);
`ifdef STORE_BUFFER_COALESCE_EN
        checkOutput("dupCount", 32'(count), 32'd1);
`else
        checkOutput("dupCount", 32'(count), 32'd2);
`endif
        checkOutput("fwdYoungValid", 32'(fwd_data_valid), 32'd1);
        checkOutput("fwdYoungData",  fwd_data,            32'h22);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300);
        checkOutput("fwdMiss", 32'(fwd_data_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h200);
        checkOutput("fwdNoReq", 32'(fwd_data_valid), 32'd0);
        applyStimulus(1'b1, 32'h500, 32'h55, 1'b0, 1'b1, 32'h500);
        checkOutput("fwdEnqInvisible", 32'(fwd_data_valid), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h500);
        checkOutput("fwdNextValid", 32'(fwd_data_valid), 32'd1);
        checkOutput("fwdNextData",  fwd_data,            32'h55);

`ifndef STORE_BUFFER_COALESCE_EN
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200);
        checkOutput("dupDrainOld",    drain_data, 32'h11);
        checkOutput("dupFwdStillNew", fwd_data,   32'h22);
        tick();
`endif
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("dupDrainNew", drain_data, 32'h22);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h500);
        checkOutput("headSearchable", 32'(fwd_data_valid), 32'd1);
        checkOutput("headFwdData",    fwd_data,            32'h55);
        checkOutput("headDrainData",  drain_data,          32'h55);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h500);
        checkOutput("postDrainEmpty", 32'(empty),          32'd1);
        checkOutput("postDrainMiss",  32'(fwd_data_valid), 32'd0);

        // Enqueue every cycle while draining every cycle: occupancy holds at one across wraps.
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b1, 32'h600 + 32'(4 * j), 32'hC0 + 32'(j), 1'b1, 1'b0, 32'h0);
            if (j > 0) begin
                checkOutput("wrapOrder", drain_data, 32'hC0 + 32'(j - 1));
                checkOutput("wrapCount", 32'(count), 32'd1);
            end
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("wrapLast", drain_data, 32'hC9);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrapEmpty", 32'(empty), 32'd1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h700 + 32'(4 * i), 32'h71 + 32'(i), 1'b0, 1'b0, 32'h0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("preRstCount", 32'(count), 32'd3);
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h704);
        checkOutput("midRstCount",    32'(count),          32'd0);
        checkOutput("midRstDrainVal", 32'(drain_valid),    32'd0);
        checkOutput("midRstEmpty",    32'(empty),          32'd1);
        checkOutput("midRstFwdMiss",  32'(fwd_data_valid), 32'd0);
        checkOutput("midRstStReady",  32'(st_ready),       32'd1);

        applyStimulus(1'b1, 32'h400, 32'h5, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h400, 32'h6, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
`ifdef STORE_BUFFER_COALESCE_EN
        checkOutput("coalCount", 32'(count), 32'd1);
        checkOutput("coalData",  drain_data, 32'h6);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
`else
        checkOutput("coalCount", 32'(count), 32'd2);
        checkOutput("coalFirst", drain_data, 32'h5);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("coalSecond", drain_data, 32'h6);
        tick();
`endif
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("finalEmpty", 32'(empty), 32'd1);

        boundArmed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
